demux_scheduler: RTL
====================

# demux_scheduler

Round-robin scheduler that shares the 1-to-4 serial demultiplexer (`din`, `addr[1:0]` → `dout[3:0]`) between four requesters. It arbitrates among pending channels, captures the winner's parallel payload, and drives the demux `addr` and `din` to shift that payload MSB-first to the matching output, with a `frame` qualifier. It sits directly in front of the demux in the lab datapath and replaces free-running testbench stimulus on `din` and `addr`.

## Interface
- `WIDTH`, default 8: payload bits per frame; must be ≥ 2.
- `GAP`, default 1: idle cycles inserted after each frame; must be ≥ 0.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `req`  in  4  per-channel request, level-sensitive.
- `data`  in  4*WIDTH  packed payloads; channel i is `data[i*WIDTH +: WIDTH]`.
- `grant`  out  4  one-hot acknowledge, one-cycle pulse; payload has been captured.
- `din`  out  1  serial bit to the demux.
- `addr`  out  2  demux select = channel being served.
- `frame`  out  1  high while `din` carries a valid bit.
- `busy`  out  1  high in SHIFT and GAP states.

## Operation
- States:
  - IDLE: arbitration, no output activity.
  - SHIFT: `WIDTH` cycles, or `WIDTH+1` with parity enabled.
  - GAP: `GAP` cycles.
- Round-robin pointer `last` (2 bits), reset value 3. Priority order is `last+1, last+2, last+3, last` (mod 4), so channel 0 wins first after reset.
- IDLE with `req != 0`: on the next edge
  - update `last` to the winner;
  - load the shift register with the winner's payload;
  - drive `addr` to the winner;
  - go to SHIFT.
- IDLE with `req == 0`: stay in IDLE.
- SHIFT: `din` = current MSB, register shifts left each cycle, bit counter counts 0..N-1. After the last bit:
  - go to GAP if `GAP > 0`;
  - otherwise go to IDLE.
- GAP: counter counts `GAP` cycles, then go to IDLE.
- `grant[winner]` is high only in the first SHIFT cycle. A requester drops `req` or presents new data after seeing it. A `req` still high when the scheduler is next in IDLE is a new request.
- `req` and `data` are ignored outside IDLE. Changes mid-frame have no effect.
- `addr` holds the last served channel through GAP and IDLE. It changes only on capture.
- `din = 0` whenever `frame = 0`.

## Timing
- Reset values: `grant = 0`, `din = 0`, `addr = 0`, `frame = 0`, `busy = 0`. State is IDLE, `last = 3`.
- `rst` asserted at any time, including mid-frame: outputs take reset values immediately, without waiting for a clock edge. The frame is aborted and no grant is issued.
- Latency: `req` sampled high in IDLE at edge k. Then in cycles k+1 .. k+N:
  - `frame = 1`;
  - `addr` = winner;
  - `din` = payload bit WIDTH-1 down to 0;
  - `grant` is high in cycle k+1 only.
- Throughput with continuous requests: one frame every N + GAP + 1 cycles. This is 10 cycles for the defaults.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `DEMUX_SCHED_PARITY_EN` defined:
  - N = WIDTH+1;
  - after the payload LSB, one extra `frame = 1` cycle carries even parity, i.e. the XOR of all payload bits.
- `DEMUX_SCHED_PARITY_EN` undefined:
  - N = WIDTH;
  - no parity cycle;
  - `frame` falls directly after the LSB.

## Test plan
1. Single request, defaults: `req = 4'b0100`, channel 2 data `8'hA5` → `grant = 4'b0100` for one cycle. Then `addr = 2` with `frame = 1` for 8 cycles, `din` = 1,0,1,0,0,1,0,1. Then one GAP cycle, then `busy = 0`.
2. Fairness: `req = 4'hF` held → grants in order 0,1,2,3,0 with consecutive grants exactly 10 cycles apart.
3. Pointer continuity: after channel 1 is served, raise `req = 4'b1010` together → channel 3 is granted first, then channel 1.
4. Reset mid-frame: assert `rst` during the 4th bit → `din`, `frame`, `busy`, `grant` and `addr` are 0 before the next edge. After release, with `req = 4'b1001`, channel 0 is granted first.
5. Parity: with `DEMUX_SCHED_PARITY_EN`, payload `8'h07` → 9 `frame` cycles, last bit = 1. Without the macro → 8 `frame` cycles.
6. `GAP = 0` with `req = 4'b0011` held → frames separated by exactly one `frame = 0` IDLE cycle. `addr` alternates 0,1. `din = 0` in the gap cycle.

Source files
------------

// File: rtl/demux_scheduler.sv
// Round-robin scheduler feeding a 1-to-4 serial demux: arbitrates, captures a payload, shifts it MSB-first.
// Optional even-parity trailer bit when DEMUX_SCHED_PARITY_EN is defined.
module demux_scheduler #(
    parameter int WIDTH = 8,
    parameter int GAP   = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [3:0]           i_req,
    input  logic [4*WIDTH-1:0]   i_data,
    output logic [3:0]           o_grant,
    output logic                 o_din,
    output logic [1:0]           o_addr,
    output logic                 o_frame,
    output logic                 o_busy
);

`ifdef DEMUX_SCHED_PARITY_EN
    localparam int N = WIDTH + 1;
`else
    localparam int N = WIDTH;
`endif
    localparam int CMAX = (N > GAP) ? N : GAP;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] N_LAST = CW'(N - 1);
    localparam logic [CW-1:0] G_LAST = (GAP > 0) ? CW'(GAP - 1) : '0;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

    state_t            r_state;
    logic [1:0]        r_last;
    logic [WIDTH-1:0]  r_sreg;
    logic [CW-1:0]     r_cnt;
    logic [3:0]        r_grant;
    logic              r_din;
    logic [1:0]        r_addr;
    logic              r_frame;
    logic              r_busy;
`ifdef DEMUX_SCHED_PARITY_EN
    logic              r_par;
`endif

    logic [1:0]        w_win;
    logic [1:0]        w_idx;
    logic              w_any;
    logic [WIDTH-1:0]  w_payload;

    // Walk priority from lowest to highest so the highest-priority requester is written last.
    always_comb begin
        w_any = |i_req;
        w_win = r_last;
        w_idx = '0;
        for (int i = 4; i >= 1; i--) begin
            w_idx = r_last + 2'(i);
            if (i_req[w_idx]) w_win = w_idx;
        end
    end

    assign w_payload = i_data[int'(w_win)*WIDTH +: WIDTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_last  <= 2'd3;
            r_sreg  <= '0;
            r_cnt   <= '0;
            r_grant <= '0;
            r_din   <= 1'b0;
            r_addr  <= '0;
            r_frame <= 1'b0;
            r_busy  <= 1'b0;
`ifdef DEMUX_SCHED_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_grant <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state <= S_SHIFT;
                        r_last  <= w_win;
                        r_addr  <= w_win;
                        r_grant <= 4'b0001 << w_win;
                        r_sreg  <= {w_payload[WIDTH-2:0], 1'b0};
                        r_din   <= w_payload[WIDTH-1];
                        r_frame <= 1'b1;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
`ifdef DEMUX_SCHED_PARITY_EN
                        r_par   <= ^w_payload;
`endif
                    end
                end
                S_SHIFT: begin
                    if (r_cnt == N_LAST) begin
                        r_din   <= 1'b0;
                        r_frame <= 1'b0;
                        r_cnt   <= '0;
                        if (GAP > 0) begin
                            r_state <= S_GAP;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt  <= r_cnt + CW'(1);
                        r_sreg <= r_sreg << 1;
`ifdef DEMUX_SCHED_PARITY_EN
                        r_din  <= (r_cnt == CW'(WIDTH - 1)) ? r_par : r_sreg[WIDTH-1];
`else
                        r_din  <= r_sreg[WIDTH-1];
`endif
                    end
                end
                S_GAP: begin
                    if (r_cnt == G_LAST) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_grant = r_grant;
    assign o_din   = r_din;
    assign o_addr  = r_addr;
    assign o_frame = r_frame;
    assign o_busy  = r_busy;

endmodule
